// File: rtl/core_sequencer_if.sv
// Fetch and data-memory handshake bundle between the sequencer and the memories.
interface core_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/core_sequencer.sv
// Multicycle control sequencer for the 16-bit RISC core: owns PC and IR,
// runs the fetch handshake and steps decode/execute/memory/writeback.
module core_sequencer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    core_sequencer_if.master  mem,
    output logic [15:0]       ir,
    input  logic              is_ldst,
    input  logic              is_load,
    input  logic              is_branch,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              writes_rd,
    input  logic              sets_flags,
    output logic              rf_we,
    output logic              flags_we,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    // Branch destinations are halfword aligned, so bit 0 of the target is dropped.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_q;
    logic              fetch_req;
    logic              data_req;
    logic              data_we;
    logic              rf_we_q;
    logic              flags_we_q;
    logic              retire_q;

    // Single registered FSM: every output and strobe is produced here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            ir_q       <= 16'h0000;
            fetch_req  <= 1'b0;
            data_req   <= 1'b0;
            data_we    <= 1'b0;
            rf_we_q    <= 1'b0;
            flags_we_q <= 1'b0;
            retire_q   <= 1'b0;
        end else begin
            retire_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            flags_we_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (fetch_req) begin
                        if (mem.imem_ack) begin
                            ir_q      <= mem.imem_rdata;
                            pc_q      <= pc_q + ADDR_W'(2);
                            fetch_req <= 1'b0;
                            state_q   <= DECODE;
                        end
                    end else if (!hold) begin
                        fetch_req <= 1'b1;
                    end
                end
                DECODE: begin
                    state_q <= EXEC;
                end
                EXEC: begin
                    flags_we_q <= sets_flags & ~is_branch;
                    if (is_branch) begin
                        if (branch_taken) begin
                            pc_q <= branch_target & ALIGN_MASK;
                        end
                        if (branch_taken && writes_rd) begin
                            rf_we_q <= 1'b1;
                            state_q <= WB;
                        end else begin
                            retire_q <= 1'b1;
                            state_q  <= FETCH;
                        end
                    end else if (is_ldst) begin
                        data_req <= 1'b1;
                        data_we  <= ~is_load;
                        state_q  <= MEM;
                    end else if (writes_rd) begin
                        rf_we_q <= 1'b1;
                        state_q <= WB;
                    end else begin
                        retire_q <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
                MEM: begin
                    if (mem.dmem_ack) begin
                        data_req <= 1'b0;
                        data_we  <= 1'b0;
                        if (data_we) begin
                            retire_q <= 1'b1;
                            state_q  <= FETCH;
                        end else begin
                            rf_we_q <= 1'b1;
                            state_q <= WB;
                        end
                    end
                end
                WB: begin
                    retire_q <= 1'b1;
                    state_q  <= FETCH;
                end
                default: begin
                    fetch_req <= 1'b0;
                    data_req  <= 1'b0;
                    data_we   <= 1'b0;
                    state_q   <= FETCH;
                end
            endcase
        end
    end

    assign mem.imem_req  = fetch_req;
    assign mem.imem_addr = pc_q;
    assign mem.dmem_req  = data_req;
    assign mem.dmem_we   = data_we;
    assign ir            = ir_q;
    assign pc            = pc_q;
    assign rf_we         = rf_we_q;
    assign flags_we      = flags_we_q;
    assign retire        = retire_q;
    assign state         = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: a toy decoder derived from IR, memories
// with random wait states, and a per-instruction reference model checked at retire.
module tb_core_sequencer;

    localparam int ADDR_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] ir;
    logic        is_ldst = 1'b0;
    logic        is_load = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        writes_rd = 1'b0;
    logic        sets_flags = 1'b0;
    logic        rf_we;
    logic        flags_we;
    logic [15:0] pc;
    logic        retire;
    logic [2:0]  state;

    core_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    core_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .hold          (hold),
        .mem           (bus),
        .ir            (ir),
        .is_ldst       (is_ldst),
        .is_load       (is_load),
        .is_branch     (is_branch),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .writes_rd     (writes_rd),
        .sets_flags    (sets_flags),
        .rf_we         (rf_we),
        .flags_we      (flags_we),
        .pc            (pc),
        .retire        (retire),
        .state         (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: one instruction in flight at a time.
    logic [15:0] model_pc;
    logic [15:0] cur_word;
    int          cur_di;
    int          cur_dd;
    bit          have_instr;
    int          cyc, rf_cnt, fl_cnt, ld_cyc, st_cyc;
    int          retired = 0;
    int          iwait = -1;
    int          dwait = -1;
    int          next_dd = -1;
    int          pend_di;
    bit          dmem_en = 1'b1;
    bit          dmem_force = 1'b0;
    logic [15:0] forced[$];

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Clear the model as if the core had just come out of reset or idle.
    task automatic restartModel();
        model_pc   = 16'h0000;
        have_instr = 1'b0;
        cyc        = 1;
        rf_cnt     = 0;
        fl_cnt     = 0;
        ld_cyc     = 0;
        st_cyc     = 0;
        iwait      = -1;
        dwait      = -1;
    endtask

    // Compare everything observed for the finished instruction against the rules.
    task automatic checkRetire();
        logic        br, ls, ld, taken, wb;
        int          exp_cyc;
        logic [15:0] nxt;
        checkOutput("retire_has_instr", 32'(have_instr), 32'd1);
        if (have_instr) begin
            br      = (cur_word[15:14] == 2'b11);
            ls      = (cur_word[15:14] == 2'b10);
            ld      = ls && cur_word[13];
            taken   = br && cur_word[13];
            wb      = br ? (taken && cur_word[12]) : (ls ? ld : cur_word[12]);
            exp_cyc = 4 + cur_di + (ls ? 1 + cur_dd : 0) + (wb ? 1 : 0);
            nxt     = taken ? {cur_word[7:0], cur_word[7:1], 1'b0} : model_pc + 16'd2;
            checkOutput("cycles", 32'(cyc - 1), 32'(exp_cyc));
            checkOutput("rf_we_count", 32'(rf_cnt), 32'(wb));
            checkOutput("flags_we_count", 32'(fl_cnt), 32'(!br && cur_word[11]));
            checkOutput("load_cycles", 32'(ld_cyc), 32'(ld ? 1 + cur_dd : 0));
            checkOutput("store_cycles", 32'(st_cyc), 32'((ls && !ld) ? 1 + cur_dd : 0));
            checkOutput("ir", 32'(ir), 32'(cur_word));
            checkOutput("pc_after", 32'(pc), 32'(nxt));
            model_pc = nxt;
            retired++;
        end
        have_instr = 1'b0;
    endtask

    // One clock: sample on the falling edge, update model, drive decoder and memories.
    task automatic applyStimulus();
        logic [15:0] word;
        @(negedge clk);
        cyc++;
        if (flags_we) fl_cnt++;
        if (retire) begin
            checkRetire();
            cyc    = 1;
            fl_cnt = 0;
            rf_cnt = 0;
            ld_cyc = 0;
            st_cyc = 0;
        end
        if (rf_we) rf_cnt++;
        if (bus.dmem_req) begin
            if (bus.dmem_we) st_cyc++;
            else ld_cyc++;
        end

        is_branch     = (ir[15:14] == 2'b11);
        is_ldst       = (ir[15:14] == 2'b10);
        is_load       = ir[13];
        branch_taken  = ir[13];
        writes_rd     = ir[12];
        sets_flags    = ir[11];
        branch_target = {ir[7:0], ir[7:0]};

        if (bus.imem_req) begin
            checkOutput("imem_addr", 32'(bus.imem_addr), 32'(model_pc));
            if (iwait < 0) begin
                iwait   = $urandom_range(0, 3);
                pend_di = iwait;
            end
            if (iwait == 0) begin
                word           = (forced.size() > 0) ? forced.pop_front() : 16'($urandom);
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = word;
                cur_word       = word;
                cur_di         = pend_di;
                have_instr     = 1'b1;
                iwait          = -1;
            end else begin
                bus.imem_ack = 1'b0;
                iwait--;
            end
        end else begin
            bus.imem_ack = 1'b0;
            iwait        = -1;
        end

        if (!dmem_en) begin
            bus.dmem_ack = dmem_force;
        end else if (bus.dmem_req) begin
            if (dwait < 0) begin
                dwait   = (next_dd >= 0) ? next_dd : $urandom_range(0, 3);
                next_dd = -1;
                cur_dd  = dwait;
            end
            if (dwait == 0) begin
                bus.dmem_ack = 1'b1;
                dwait        = -1;
            end else begin
                bus.dmem_ack = 1'b0;
                dwait--;
            end
        end else begin
            bus.dmem_ack = 1'b0;
            dwait        = -1;
        end
    endtask

    initial begin
        int guard;
        int target;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.dmem_ack   = 1'b0;
        restartModel();

        // Reset values after two edges with reset low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_ir", 32'(ir), 32'd0);
        checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_flags_we", 32'(flags_we), 32'd0);
        checkOutput("rst_retire", 32'(retire), 32'd0);

        // Directed opener: ALU wb+flags, slow load, store, taken branch, BL,
        // untaken branch, jump to 0xFFFE (wrap), plain ALU; then random words.
        forced.push_back(16'h1800);
        forced.push_back(16'hA000);
        forced.push_back(16'h8000);
        forced.push_back(16'hE101);
        forced.push_back(16'hF101);
        forced.push_back(16'hD000);
        forced.push_back(16'hE0FF);
        forced.push_back(16'h0000);
        forced.push_back(16'h0800);
        next_dd = 3;
        reset   = 1'b1;
        restartModel();

        applyStimulus();
        checkOutput("req_after_release", 32'(bus.imem_req), 32'd1);
        checkOutput("addr_after_release", 32'(bus.imem_addr), 32'd0);

        guard = 0;
        while (retired < 150 && guard < 20000) begin
            applyStimulus();
            guard++;
        end
        checkOutput("random_phase_complete", 32'(retired >= 150), 32'd1);

        // Park a load in MEM, then pull reset while the request is outstanding.
        forced.delete();
        forced.push_back(16'hA000);
        dmem_en    = 1'b0;
        dmem_force = 1'b0;
        guard      = 0;
        while (!bus.dmem_req && guard < 50) begin
            applyStimulus();
            guard++;
        end
        checkOutput("reach_mem_state", 32'(bus.dmem_req), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_dmem_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("midrst_dmem_we", 32'(bus.dmem_we), 32'd0);
        checkOutput("midrst_state", 32'(state), 32'd0);
        checkOutput("midrst_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("midrst_pc", 32'(pc), 32'd0);
        checkOutput("midrst_ir", 32'(ir), 32'd0);

        // Release with hold high and a stray data ack: nothing may start.
        hold         = 1'b1;
        dmem_force   = 1'b1;
        bus.dmem_ack = 1'b1;
        reset        = 1'b1;
        restartModel();
        repeat (5) begin
            applyStimulus();
            checkOutput("hold_no_req", 32'(bus.imem_req), 32'd0);
            checkOutput("late_ack_ignored", 32'(bus.dmem_req), 32'd0);
            checkOutput("hold_state", 32'(state), 32'd0);
            checkOutput("hold_no_rf_we", 32'(rf_we), 32'd0);
        end
        hold         = 1'b0;
        dmem_force   = 1'b0;
        dmem_en      = 1'b1;
        bus.dmem_ack = 1'b0;
        cyc          = 1;
        applyStimulus();
        checkOutput("req_after_hold", 32'(bus.imem_req), 32'd1);
        checkOutput("addr_after_hold", 32'(bus.imem_addr), 32'd0);

        target = retired + 20;
        guard  = 0;
        while (retired < target && guard < 5000) begin
            applyStimulus();
            guard++;
        end
        checkOutput("final_phase_complete", 32'(retired >= target), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
